// File: rtl/core_pkg.sv
// Shared stage codes and PC constants for the scalar core's fetch/decode/exec/mem/write stages.
package core_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WRITE  = 3'd4,
        ST_HALT   = 3'd5,
        ST_IDLE   = 3'd7
    } state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] INSTR_STRIDE = 32'd4;

endpackage : core_pkg

// File: rtl/core_sequencer.sv
// Multicycle control FSM: owns the PC, next-PC select, memory handshake, halt and pause.
// Build option MEM_SKIP_EN: non-memory instructions bypass the MEM stage (4-cycle ALU ops).
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    output logic [STATE_W-1:0]  state,
    output logic [31:0]         pc,
    input  logic                dec_is_mem,
    input  logic                br_taken,
    input  logic [31:0]         br_target,
    output logic                mem_req,
    input  logic                mem_ack,
    output logic                wb_en,
    output logic                halted,
    output logic                misalign,
    output logic [RETIRE_W-1:0] retired
);

    state_e              state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         next_pc_q, next_pc_d;
    logic                halted_q, halted_d;
    logic                misalign_q, misalign_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;

    // NOTE: synchronous reset lives inside the clocked block, so it wins on the same edge even mid-MEM.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            next_pc_q  <= RESET_PC;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            next_pc_q  <= next_pc_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
            retired_q  <= retired_d;
        end
    end

    // NOTE: every next-state variable is defaulted to its hold value first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        next_pc_d  = next_pc_q;
        halted_d   = halted_q;
        misalign_d = misalign_q;
        retired_d  = retired_q;

        case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (br_taken) begin
                    next_pc_d = {br_target[31:2], 2'b00};
                    if (br_target[1:0] != 2'b00) misalign_d = 1'b1;
                end else begin
                    next_pc_d = pc_q + INSTR_STRIDE;
                end
`ifdef MEM_SKIP_EN
                state_d = dec_is_mem ? ST_MEM : ST_WRITE;
`else
                state_d = ST_MEM;
`endif
            end
            // An ack with no request outstanding cannot advance a load/store.
            ST_MEM:    if (!dec_is_mem || mem_ack) state_d = ST_WRITE;
            ST_WRITE: begin
                pc_d      = next_pc_q;
                retired_d = retired_q + RETIRE_W'(1);
                if (next_pc_q == pc_q) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (!start) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign state    = state_q;
    assign pc       = pc_q;
    assign halted   = halted_q;
    assign misalign = misalign_q;
    assign retired  = retired_q;
    assign mem_req  = (state_q == ST_MEM) && dec_is_mem;
    assign wb_en    = (state_q == ST_WRITE);

endmodule : core_sequencer

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: directed instructions push expected retire records,
// a monitor pops and compares on every write-back cycle.
module tb_core_sequencer;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rstn, start, dec_is_mem, br_taken, mem_ack;
    logic [31:0] br_target;
    logic [2:0]  state;
    logic [31:0] pc, retired;
    logic        mem_req, wb_en, halted, misalign;

`ifdef MEM_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ret;
        logic        mis;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_ret = '0;
    logic        model_mis = 1'b0;

    core_sequencer #(.RESET_PC(32'h0), .RETIRE_W(32)) dut (
        .clk(clk), .rstn(rstn), .start(start), .state(state), .pc(pc),
        .dec_is_mem(dec_is_mem), .br_taken(br_taken), .br_target(br_target),
        .mem_req(mem_req), .mem_ack(mem_ack), .wb_en(wb_en), .halted(halted),
        .misalign(misalign), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Monitor: every write-back cycle retires exactly one queued instruction.
    always @(negedge clk) begin
        if (wb_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected", {63'd0, wb_en}, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_pc", {32'd0, pc}, {32'd0, e.pc});
                check("sb_retired", {32'd0, retired}, {32'd0, e.ret});
                check("sb_misalign", {63'd0, misalign}, {63'd0, e.mis});
            end
        end
    end

    task automatic wait_fetch(input string nm);
        for (int i = 0; i < 20 && state !== ST_FETCH; i++) @(negedge clk);
        check({nm, "_reach_fetch"}, {61'd0, state}, {61'd0, ST_FETCH});
    endtask

    // Drives one instruction from FETCH through WRITE; returns at the WRITE negedge.
    task automatic run_instr(input string nm, input logic [31:0] exp_pc, input logic is_mem,
                             input int ack_dly, input logic br, input logic [31:0] tgt,
                             input logic drop_start, input logic ack_noise);
        exp_t e;
        int   cyc;
        int   req_n;
        int   mem_n;
        int   exp_mem;
        wait_fetch(nm);
        check({nm, "_pc_fetch"}, {32'd0, pc}, {32'd0, exp_pc});
        model_mis = model_mis | (br && (tgt[1:0] != 2'b00));
        e.pc  = exp_pc;
        e.ret = model_ret;
        e.mis = model_mis;
        sb_q.push_back(e);
        model_ret = model_ret + 32'd1;
        dec_is_mem = is_mem;
        br_taken   = br;
        br_target  = tgt;
        mem_ack    = ack_noise;
        @(negedge clk);
        check({nm, "_decode"}, {61'd0, state}, {61'd0, ST_DECODE});
        @(negedge clk);
        check({nm, "_exec"}, {61'd0, state}, {61'd0, ST_EXEC});
        check({nm, "_req_exec"}, {63'd0, mem_req}, 64'd0);
        if (drop_start) start = 1'b0;
        @(negedge clk);
        cyc   = 3;
        req_n = 0;
        mem_n = 0;
        for (int i = 0; i < 40 && state === ST_MEM; i++) begin
            mem_n++;
            if (mem_req === 1'b1) req_n++;
            if (is_mem && i == ack_dly) mem_ack = 1'b1;
            @(negedge clk);
            cyc++;
        end
        exp_mem = is_mem ? ack_dly + 1 : (SKIP ? 0 : 1);
        check({nm, "_write"}, {61'd0, state}, {61'd0, ST_WRITE});
        check({nm, "_wb_en"}, {63'd0, wb_en}, 64'd1);
        check({nm, "_mem_cycles"}, 64'(mem_n), 64'(exp_mem));
        check({nm, "_req_cycles"}, 64'(req_n), 64'(is_mem ? ack_dly + 1 : 0));
        check({nm, "_latency"}, 64'(cyc + 1), 64'(4 + exp_mem));
        mem_ack    = 1'b0;
        br_taken   = 1'b0;
        dec_is_mem = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; dec_is_mem = 1'b0; br_taken = 1'b0;
        mem_ack = 1'b0; br_target = '0;
        repeat (2) @(negedge clk);
        check("rst_state", {61'd0, state}, {61'd0, ST_IDLE});
        check("rst_pc", {32'd0, pc}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_misalign", {63'd0, misalign}, 64'd0);
        check("rst_retired", {32'd0, retired}, 64'd0);
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_wb_en", {63'd0, wb_en}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_hold", {61'd0, state}, {61'd0, ST_IDLE});
        start = 1'b1;

        run_instr("alu0",   32'h0,  1'b0, 0, 1'b0, 32'h0,  1'b0, 1'b0);
        run_instr("alu4",   32'h4,  1'b0, 0, 1'b0, 32'h0,  1'b0, 1'b0);
        run_instr("ld8",    32'h8,  1'b1, 3, 1'b0, 32'h0,  1'b0, 1'b0);
        run_instr("brc",    32'hC,  1'b0, 0, 1'b1, 32'h14, 1'b0, 1'b0);
        run_instr("alu14",  32'h14, 1'b0, 0, 1'b0, 32'h0,  1'b0, 1'b0);
        run_instr("mis18",  32'h18, 1'b0, 0, 1'b1, 32'h16, 1'b0, 1'b0);
        run_instr("alu14b", 32'h14, 1'b0, 0, 1'b0, 32'h0,  1'b0, 1'b0);
        check("misalign_sticky", {63'd0, misalign}, 64'd1);

        run_instr("pause18", 32'h18, 1'b0, 0, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("pause_idle", {61'd0, state}, {61'd0, ST_IDLE});
        check("pause_pc", {32'd0, pc}, 64'h1C);
        repeat (3) @(negedge clk);
        check("pause_hold", {61'd0, state}, {61'd0, ST_IDLE});
        start = 1'b1;

        run_instr("ld1c_fast",  32'h1C,        1'b1, 0, 1'b0, 32'h0,         1'b0, 1'b0);
        run_instr("alu20_nack", 32'h20,        1'b0, 0, 1'b0, 32'h0,         1'b0, 1'b1);
        run_instr("br24",       32'h24,        1'b0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        run_instr("alu_top",    32'hFFFF_FFFC, 1'b0, 0, 1'b0, 32'h0,         1'b0, 1'b0);
        run_instr("br0",        32'h0,         1'b0, 0, 1'b1, 32'h14,        1'b0, 1'b0);
        // Self-jump with start dropped: halt must win over pause.
        run_instr("self14",     32'h14,        1'b0, 0, 1'b1, 32'h14,        1'b1, 1'b0);
        @(negedge clk);
        check("halt_state", {61'd0, state}, {61'd0, ST_HALT});
        check("halt_flag", {63'd0, halted}, 64'd1);
        check("halt_pc", {32'd0, pc}, 64'h14);
        check("halt_retired", {32'd0, retired}, {32'd0, model_ret});
        for (int i = 0; i < 6; i++) begin
            start = ~start;
            @(negedge clk);
        end
        check("halt_absorb", {61'd0, state}, {61'd0, ST_HALT});
        check("halt_pc_hold", {32'd0, pc}, 64'h14);

        rstn = 1'b0;
        @(negedge clk);
        model_ret = '0;
        model_mis = 1'b0;
        check("rst2_state", {61'd0, state}, {61'd0, ST_IDLE});
        check("rst2_pc", {32'd0, pc}, 64'd0);
        check("rst2_halted", {63'd0, halted}, 64'd0);
        check("rst2_misalign", {63'd0, misalign}, 64'd0);
        rstn  = 1'b1;
        start = 1'b1;

        // Load that never gets acked, killed by reset while waiting in MEM.
        wait_fetch("killmem");
        dec_is_mem = 1'b1;
        repeat (3) @(negedge clk);
        check("kill_in_mem", {61'd0, state}, {61'd0, ST_MEM});
        check("kill_req_hi", {63'd0, mem_req}, 64'd1);
        @(negedge clk);
        check("kill_req_wait", {63'd0, mem_req}, 64'd1);
        rstn = 1'b0;
        @(negedge clk);
        check("kill_state", {61'd0, state}, {61'd0, ST_IDLE});
        check("kill_req_lo", {63'd0, mem_req}, 64'd0);
        check("kill_pc", {32'd0, pc}, 64'd0);
        check("kill_retired", {32'd0, retired}, 64'd0);
        rstn = 1'b1;
        start = 1'b0;
        dec_is_mem = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_core_sequencer

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multicycle control FSM for the scalar core.
- Drives the 3-bit `state` bus consumed by fetch, decode, exec, mem and write stages.
- Owns the architectural PC and the next-PC select (sequential or branch/jump).
- Runs the memory-stage request/acknowledge handshake; detects halt (self-jump) and pause requests.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- RETIRE_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  core clock; all logic on posedge.
- rstn  input  1  synchronous, active-low reset.
- start  input  1  run enable; level-sensitive.
- state  output  3  stage code: FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4, HALT=5, IDLE=7.
- pc  output  32  current instruction address.
- dec_is_mem  input  1  current instr is load/store; valid in EXEC and MEM.
- br_taken  input  1  redirect PC; sampled at end of EXEC.
- br_target  input  32  redirect address; sampled with br_taken.
- mem_req  output  1  memory access request.
- mem_ack  input  1  memory access complete.
- wb_en  output  1  register-file write strobe.
- halted  output  1  core stopped on self-jump.
- misalign  output  1  sticky: redirect target had nonzero [1:0].
- retired  output  RETIRE_W  count of completed instructions.

Behaviour:
- Reset: synchronous on posedge while rstn=0, overriding everything, including mid-MEM. Same-edge values:
  - state=IDLE, pc=RESET_PC, next_pc=RESET_PC, halted=0, misalign=0, retired=0.
  - mem_req and wb_en go low combinationally from the state change.
- IDLE: start=1 → FETCH next cycle; otherwise stay.
- FETCH: exactly 1 cycle → DECODE. The fetch stage registers the instruction on the edge leaving FETCH.
- DECODE: 1 cycle → EXEC.
- EXEC: 1 cycle → MEM, or → WRITE under MEM_SKIP_EN. next_pc is captured on the edge leaving EXEC:
  - br_taken=1: next_pc={br_target[31:2],2'b00}; misalign set if br_target[1:0]!=0.
  - br_taken=0: next_pc=pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC → 0).
- MEM:
  - mem_req = (state==MEM) && dec_is_mem, combinational from registered state; no other source.
  - If dec_is_mem: stay in MEM until mem_ack=1 is sampled, then → WRITE. mem_req stays high every waiting cycle; there is no timeout.
  - If !dec_is_mem: 1 cycle → WRITE, mem_req=0.
  - mem_ack while mem_req=0 (any state) is ignored.
  - mem_ack already high on the first MEM cycle completes the access in 1 cycle.
- WRITE: wb_en=1 for this single cycle. On the edge leaving WRITE:
  - pc<=next_pc; retired<=retired+1, wrapping.
  - next_pc==pc (self-jump, e.g. jal x0,0) → HALT and halted<=1. Halt has priority over pause.
  - else start=0 → IDLE (pause; resume re-enters FETCH with the updated pc).
  - else → FETCH.
- HALT: absorbing. start is ignored; only rstn exits. pc holds the self-jump address.
- Outputs are registered, except mem_req and wb_en, which are decodes of registered state.
- start is sampled only in IDLE and WRITE. Deasserting it elsewhere does not abort the current instruction.
- Unused codes 6 are illegal and recover to IDLE.

Optional Feature:
- Macro: MEM_SKIP_EN.
  - Defined: EXEC with dec_is_mem=0 goes directly to WRITE; MEM is visited only for load/store. ALU-op latency is 4 cycles.
  - Undefined: every instruction passes MEM (1 cycle if !dec_is_mem). Latency is 5 cycles.
- PC/halt/misalign semantics are identical in both builds.

Decomposition:
- Shared package core_pkg:
  - state localparams ST_FETCH..ST_IDLE, with 3-bit state width.
  - RESET_PC default and the instruction byte stride (4).
- Fetch/decode/exec stages import the same state constants.
- Single flat module; no sub-module is warranted. The next-PC mux and counter are inline.

Test Plan:
- Reset, start=1, no branches, no mem, MEM_SKIP_EN undefined → state sequence 7,0,1,2,3,4,0…; pc 0→4→8 each 5 cycles; retired increments per WRITE; wb_en high one cycle per instruction.
- Load with mem_ack delayed 3 cycles → mem_req high exactly 3 cycles before ack plus the ack cycle; WRITE follows ack; pc advances by 4.
- Branch at pc=8, br_taken=1, br_target=0x14 → next fetched pc=0x14; br_target=0x16 → pc=0x14, misalign=1 and sticky.
- Self-jump at pc=0x14 (br_target=0x14) → state=5, halted=1, pc stays 0x14; start toggling has no effect; rstn=0 → state=7, pc=0, halted=0.
- start dropped mid-EXEC → instruction completes, state → IDLE after WRITE; start=1 → resumes at next pc; rstn low during MEM wait → mem_req low the next cycle, state=IDLE.
- MEM_SKIP_EN defined, ALU op then load → ALU op takes 4 cycles (no state 3); load visits MEM; pc wrap from 0xFFFF_FFFC → 0x0.
